mips_muldiv_unit: RTL and testbench

Iterative multiply/divide sequencer that owns the HI/LO register pair of the MIPS core. It executes R-type MULT, MULTU, DIV and DIVU as multi-cycle radix-2 operations and serves MTHI/MTLO writes. It also generates the stall request the pipeline controller uses to hold MFHI/MFLO readers and new mul/div issues while an operation is in flight. It sits beside the ALU in the execute stage and is driven from decoded `funct_t` values.

---
 rtl/mips_muldiv_unit.sv | 177 +++++++++++++++++
 tb/tb_mips_muldiv_unit.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/mips_muldiv_unit.sv
// mips_muldiv_unit
//   Iterative radix-2 multiply/divide sequencer owning the HI/LO pair.
//   MULT/MULTU run shift-add, DIV/DIVU run restoring shift-subtract, one
//   step per cycle for DATA_WIDTH cycles, then a fixup cycle applies the
//   sign correction and writes HI/LO. MTHI/MTLO write HI/LO directly.
// Ports
//   clk, rst        core clock, asynchronous active-high reset
//   start_i         issue strobe for funct_i
//   funct_i         decoded R-type funct code
//   rs_data_i       multiplicand / dividend / MTHI-MTLO source
//   rt_data_i       multiplier / divisor
//   hilo_rd_i       an MFHI/MFLO sits in execute
//   busy_o          operation in flight
//   done_o          one-cycle pulse after HI/LO receive a mul/div result
//   stall_o         hold request for HI/LO readers and new issues
//   hi_o, lo_o      HI and LO registers
module mips_muldiv_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [5:0]            funct_i,
  input  logic [DATA_WIDTH-1:0] rs_data_i,
  input  logic [DATA_WIDTH-1:0] rt_data_i,
  input  logic                  hilo_rd_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  stall_o,
  output logic [DATA_WIDTH-1:0] hi_o,
  output logic [DATA_WIDTH-1:0] lo_o
);

  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  typedef enum logic [1:0] {IDLE, RUN, FIXUP} state_t;

  function automatic logic [W-1:0] abs_val(input logic [W-1:0] v, input logic signed_op);
    return (signed_op && v[W-1]) ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [W-1:0] cond_neg(input logic [W-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*W-1:0] cond_neg2(input logic [2*W-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic             done_q, done_d;
  logic             is_mul_q, is_mul_d;
  logic             negq_q, negq_d;   // product sign (mul) or quotient sign (div)
  logic             negr_q, negr_d;   // remainder sign
  // Datapath: acc holds product upper half / partial remainder; wrk holds
  // the multiplier shifting out and product lower half, or the dividend
  // shifting out and quotient shifting in.
  logic [W-1:0]     acc_q, acc_d, wrk_q, wrk_d, opnd_q, opnd_d;

  logic [W:0]       mul_sum;
  logic [W:0]       div_shift;
  logic [W:0]       div_diff;
  logic             signed_op, mul_op;

  assign mul_sum   = {1'b0, acc_q} + (wrk_q[0] ? {1'b0, opnd_q} : '0);
  assign div_shift = {acc_q, wrk_q[W-1]};
  // Partial remainder stays below the divisor, so the W+1-bit difference
  // has a reliable sign bit.
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign signed_op = (funct_i == F_MULT) || (funct_i == F_DIV);
  assign mul_op    = (funct_i == F_MULT) || (funct_i == F_MULTU);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    is_mul_d = is_mul_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    acc_d    = acc_q;
    wrk_d    = wrk_q;
    opnd_d   = opnd_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          case (funct_i)
            F_MULT, F_MULTU, F_DIV, F_DIVU: begin
              wrk_d    = abs_val(rs_data_i, signed_op);
              opnd_d   = abs_val(rt_data_i, signed_op);
              acc_d    = '0;
              cnt_d    = '0;
              is_mul_d = mul_op;
              // A zero divisor leaves the all-ones quotient unnegated; the
              // remainder fixup then reproduces rs exactly.
              negq_d   = signed_op && (rs_data_i[W-1] ^ rt_data_i[W-1]) &&
                         (mul_op || (rt_data_i != '0));
              negr_d   = signed_op && rs_data_i[W-1];
              state_d  = RUN;
            end
            F_MTHI:  hi_d = rs_data_i;
            F_MTLO:  lo_d = rs_data_i;
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(W - 1)) state_d = FIXUP;
        if (is_mul_q) begin
          acc_d = mul_sum[W:1];
          wrk_d = {mul_sum[0], wrk_q[W-1:1]};
        end else begin
          acc_d = div_diff[W] ? div_shift[W-1:0] : div_diff[W-1:0];
          wrk_d = {wrk_q[W-2:0], ~div_diff[W]};
        end
      end
      FIXUP: begin
        if (is_mul_q) begin
          {hi_d, lo_d} = cond_neg2({acc_q, wrk_q}, negq_q);
        end else begin
          lo_d = cond_neg(wrk_q, negq_q);
          hi_d = cond_neg(acc_q, negr_q);
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      is_mul_q <= 1'b0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      is_mul_q <= is_mul_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
    end
  end

  always_ff @(posedge clk) begin
    acc_q  <= acc_d;
    wrk_q  <= wrk_d;
    opnd_q <= opnd_d;
  end

  assign busy_o  = (state_q != IDLE);
  assign done_o  = done_q;
  assign stall_o = busy_o & (hilo_rd_i | start_i);
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
module tb_mips_muldiv_unit;

  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [5:0]  funct_i;
  logic [31:0] rs_data_i, rt_data_i;
  logic        hilo_rd_i;
  logic        busy_o, done_o, stall_o;
  logic [31:0] hi_o, lo_o;

  int n_cmp = 0;
  int n_bad = 0;

  mips_muldiv_unit #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .funct_i(funct_i),
    .rs_data_i(rs_data_i), .rt_data_i(rt_data_i), .hilo_rd_i(hilo_rd_i),
    .busy_o(busy_o), .done_o(done_o), .stall_o(stall_o),
    .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [5:0]  funct;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a falling edge; issues the op on the next rising edge and
  // returns at the falling edge of the first non-busy cycle.
  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        output int busy_cnt, output logic done_seen);
    funct_i = f; rs_data_i = a; rt_data_i = b; start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    busy_cnt = 0; done_seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (busy_o) busy_cnt++;
      else begin
        done_seen = done_o;
        break;
      end
    end
  endtask

  initial begin
    int   bc;
    logic ds;
    int   stall_cnt, done_cnt;

    vecs[0] = '{"multu_max",  F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1] = '{"mult_neg3x5", F_MULT, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[2] = '{"mult_7x6_b2b", F_MULT, 32'h00000007, 32'h00000006, 32'h00000000, 32'h0000002A};
    vecs[3] = '{"div_neg7_2",  F_DIV,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[4] = '{"divu_100_7",  F_DIVU, 32'd100,      32'd7,        32'd2,        32'd14};
    vecs[5] = '{"divu_by0",    F_DIVU, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF};
    vecs[6] = '{"div_min_m1",  F_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[7] = '{"div_neg_by0", F_DIV,  32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
    vecs[8] = '{"mult_min_min", F_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[9] = '{"div_7_m2",    F_DIV,  32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};

    rst = 1'b1; start_i = 1'b0; funct_i = '0; rs_data_i = '0; rt_data_i = '0; hilo_rd_i = 1'b0;
    #1;
    check("rst_busy",  busy_o,  1'b0);
    check("rst_done",  done_o,  1'b0);
    check("rst_stall", stall_o, 1'b0);
    check("rst_hi",    hi_o,    32'h0);
    check("rst_lo",    lo_o,    32'h0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Each vector issues in the done_o cycle of the previous one.
    for (int v = 0; v < 10; v++) begin
      run_op(vecs[v].funct, vecs[v].rs, vecs[v].rt, bc, ds);
      check({vecs[v].name, "_busy_cycles"}, bc, 33);
      check({vecs[v].name, "_done"}, ds, 1'b1);
      check({vecs[v].name, "_hi"}, hi_o, vecs[v].exp_hi);
      check({vecs[v].name, "_lo"}, lo_o, vecs[v].exp_lo);
    end
    @(negedge clk);
    check("done_single_pulse", done_o, 1'b0);

    // Unrecognized funct: no effect.
    funct_i = 6'h20; rs_data_i = 32'h55555555; start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    check("bad_funct_busy", busy_o, 1'b0);
    check("bad_funct_hi", hi_o, 32'h00000001);
    check("bad_funct_lo", lo_o, 32'hFFFFFFFD);
    @(negedge clk);

    // Busy MULT with MFHI/MFLO reader present and an MTHI issued mid-flight.
    hilo_rd_i = 1'b1;
    check("idle_no_stall", stall_o, 1'b0);
    funct_i = F_MULT; rs_data_i = 32'd3; rt_data_i = 32'd4; start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    stall_cnt = 0;
    for (int i = 0; i < 33; i++) begin
      @(negedge clk);
      if (stall_o && busy_o) stall_cnt++;
      if (i == 5) begin
        funct_i = F_MTHI; rs_data_i = 32'hDEADBEEF; start_i = 1'b1;
      end else begin
        start_i = 1'b0;
      end
    end
    check("stall_every_busy_cycle", stall_cnt, 33);
    @(negedge clk);
    hilo_rd_i = 1'b0;
    check("mult_mthi_done", done_o, 1'b1);
    check("mult_mthi_ignored_hi", hi_o, 32'h0);
    check("mult_mthi_lo", lo_o, 32'd12);
    check("done_cycle_no_stall", stall_o, 1'b0);
    @(negedge clk);

    // MTLO while idle.
    funct_i = F_MTLO; rs_data_i = 32'hCAFEBABE; start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    check("mtlo_lo", lo_o, 32'hCAFEBABE);
    check("mtlo_hi_kept", hi_o, 32'h0);
    check("mtlo_busy", busy_o, 1'b0);
    check("mtlo_done", done_o, 1'b0);
    @(negedge clk);
    check("mtlo_done_next", done_o, 1'b0);

    // Asynchronous reset in the middle of a DIV.
    funct_i = F_DIV; rs_data_i = 32'd1000; rt_data_i = 32'd3; start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    repeat (10) @(negedge clk);
    check("pre_rst_busy", busy_o, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_busy", busy_o, 1'b0);
    check("async_rst_hi", hi_o, 32'h0);
    check("async_rst_lo", lo_o, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_o || busy_o) done_cnt++;
    end
    check("no_done_after_rst", done_cnt, 0);
    run_op(F_DIVU, 32'd100, 32'd7, bc, ds);
    check("post_rst_busy_cycles", bc, 33);
    check("post_rst_done", ds, 1'b1);
    check("post_rst_hi", hi_o, 32'd2);
    check("post_rst_lo", lo_o, 32'd14);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
